// File: rtl/up_down_counter_n_bit_pkg.sv
// rtl/up_down_counter_n_bit_pkg.sv - shared direction and mode encodings for the up/down counter
package up_down_counter_n_bit_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef struct packed {
    logic limit_pulse;
    logic overflow;
  } counter_flags_t;

endpackage

// File: rtl/up_down_counter_n_bit_incrementer.sv
// rtl/up_down_counter_n_bit_incrementer.sv - combinational N-bit add/subtract by a fixed step
module incrementer_n_bit
  import up_down_counter_n_bit_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter longint unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic             up,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH:0] sum_ext;

  // The extra top bit is the carry on add and the borrow on subtract.
  always_comb begin
    if (up == DIR_UP) begin
      sum_ext = {1'b0, value} + {1'b0, STEP_W};
    end else begin
      sum_ext = {1'b0, value} - {1'b0, STEP_W};
    end
    result = sum_ext[WIDTH-1:0];
    carry  = sum_ext[WIDTH];
  end

endmodule

// File: rtl/up_down_counter_n_bit.sv
// rtl/up_down_counter_n_bit.sv - loadable up/down counter with wrap or saturate and sticky overflow
module up_down_counter_n_bit
  import up_down_counter_n_bit_pkg::*;
#(
  parameter int              WIDTH    = 16,
  parameter longint unsigned STEP     = 1,
  parameter int              SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             limit_pulse,
  output logic             overflow
);

  logic [WIDTH-1:0] count_q, count_d;
  counter_flags_t   flags_q, flags_d;
  logic [WIDTH-1:0] inc_result;
  logic             limit_evt;

  incrementer_n_bit #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_incrementer (
    .value  (count_q),
    .up     (up),
    .result (inc_result),
    .carry  (limit_evt)
  );

  // A saturated counter pushed further still carries/borrows, so it re-flags a limit event.
  always_comb begin
    count_d              = count_q;
    flags_d.limit_pulse  = 1'b0;
    flags_d.overflow     = flags_q.overflow & ~clear_ovf;
    if (load) begin
      count_d = load_value;
    end else if (en) begin
      count_d = inc_result;
      if (limit_evt) begin
        flags_d.limit_pulse = 1'b1;
        flags_d.overflow    = 1'b1;
        if (SATURATE == MODE_SAT) begin
          count_d = (up == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      flags_q <= '0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign count       = count_q;
  assign limit_pulse = flags_q.limit_pulse;
  assign overflow    = flags_q.overflow;

endmodule
